// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants.
package cpu_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage : cpu_pkg

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker: loadable down-counter with a one-cycle done pulse.
module md_busy_counter
    import cpu_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic issue_i,
    output logic busy_o,
    output logic done_o
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    // State, counter and done-pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state: load on issue, count down while busy, pulse done on the final edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy_o = 1'b0;
        done_o = done_q;
        if (state_q == BUSY) begin
            busy_o = 1'b1;
        end
    end

endmodule : md_busy_counter

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use / mult-div stalls, branch flushes, stall perf counter.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_md_start,
    input  logic              ID_md_use,
    input  logic              EX_MemRead,
    input  logic [REG_W-1:0]  EX_rt,
    input  logic              EX_branch_taken,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IFID_flush,
    output logic              IDEX_flush,
    output logic              md_issue,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cycles
);

    logic              lu;
    logic              mdh;
    logic              stall;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // Hazard detection on the ID-stage operands against EX and the mult/div unit.
    always_comb begin
        lu = EX_MemRead && (EX_rt != ZERO_REG) &&
             ((ID_uses_rs && (ID_rs == EX_rt)) || (ID_uses_rt && (ID_rt == EX_rt)));
        mdh   = md_busy && (ID_md_start || ID_md_use);
        stall = lu || mdh;
    end

    // Pipeline enables/flushes: reset holds everything frozen, branch beats stall.
    always_comb begin
        PC_write   = 1'b1;
        IFID_write = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        md_issue   = 1'b0;
        if (!reset_n) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (EX_branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (stall) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else begin
            md_issue = ID_md_start && !md_busy;
        end
    end

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .issue_i (md_issue),
        .busy_o  (md_busy),
        .done_o  (md_done)
    );

    // Saturating count of cycles lost to stalls (branch-flushed cycles excluded).
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !EX_branch_taken && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MD_LATENCY=4, narrow perf counter to reach saturation).
module tb_hazard_stall_ctrl;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    ID_rs, ID_rt, EX_rt;
    logic          ID_uses_rs, ID_uses_rt, ID_md_start, ID_md_use;
    logic          EX_MemRead, EX_branch_taken;
    logic          PC_write, IFID_write, IFID_flush, IDEX_flush;
    logic          md_issue, md_busy, md_done;
    logic [PW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_stall_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (6),
        .PERF_W     (PW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_uses_rs      (ID_uses_rs),
        .ID_uses_rt      (ID_uses_rt),
        .ID_md_start     (ID_md_start),
        .ID_md_use       (ID_md_use),
        .EX_MemRead      (EX_MemRead),
        .EX_rt           (EX_rt),
        .EX_branch_taken (EX_branch_taken),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IFID_flush      (IFID_flush),
        .IDEX_flush      (IDEX_flush),
        .md_issue        (md_issue),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pipeline control vector {PC_write, IFID_write, IFID_flush, IDEX_flush}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PC_write, IFID_write, IFID_flush, IDEX_flush}, {28'd0, exp});
    endtask

    // Drive the next cycle's inputs just after the edge, then move to the mid-cycle check point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        ID_md_start = 1'b0; ID_md_use = 1'b0;
        EX_MemRead = 1'b0; EX_branch_taken = 1'b0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
    endtask

    localparam logic [3:0] CTL_NORM  = 4'b1100;
    localparam logic [3:0] CTL_STALL = 4'b0001;
    localparam logic [3:0] CTL_BR    = 4'b1111;
    localparam logic [3:0] CTL_RST   = 4'b0011;

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        ID_md_start = 1'b1;
        #3;
        chk_ctl("reset_ctl", CTL_RST);
        chk("reset_issue", md_issue, 0);
        chk("reset_busy", md_busy, 0);
        chk("reset_done", md_done, 0);
        chk("reset_perf", stall_cycles, 0);

        next_cycle(); clear_inputs();
        next_cycle(); reset_n = 1'b1;
        settle();
        chk_ctl("normal_ctl", CTL_NORM);

        // Load-use on rs: one stall cycle then normal.
        next_cycle(); set_load_use(); settle();
        chk_ctl("lu_rs_ctl", CTL_STALL);
        next_cycle(); EX_MemRead = 1'b0; settle();
        chk_ctl("lu_after_ctl", CTL_NORM);
        chk("lu_perf", stall_cycles, 1);

        // $zero destination never stalls.
        next_cycle(); clear_inputs(); EX_MemRead = 1'b1; ID_uses_rs = 1'b1; settle();
        chk_ctl("zero_reg_ctl", CTL_NORM);

        // rt matches but is not read.
        next_cycle(); clear_inputs(); EX_MemRead = 1'b1; EX_rt = 5'd9; ID_rt = 5'd9; settle();
        chk_ctl("unused_rt_ctl", CTL_NORM);
        next_cycle(); ID_uses_rt = 1'b1; settle();
        chk_ctl("lu_rt_ctl", CTL_STALL);
        next_cycle(); clear_inputs(); settle();
        chk("lu_rt_perf", stall_cycles, 2);

        // Taken branch overrides a load-use hazard and is not counted.
        next_cycle(); set_load_use(); EX_branch_taken = 1'b1; settle();
        chk_ctl("br_lu_ctl", CTL_BR);
        next_cycle(); clear_inputs(); settle();
        chk("br_lu_perf", stall_cycles, 2);

        // Mult/div issue at cycle 0, mflo waits in ID from cycle 1.
        next_cycle(); ID_md_start = 1'b1; settle();
        chk("md0_issue", md_issue, 1);
        chk("md0_busy", md_busy, 0);
        next_cycle(); ID_md_start = 1'b0; ID_md_use = 1'b1; settle();
        chk("md1_busy", md_busy, 1);
        chk_ctl("md1_ctl", CTL_STALL);
        next_cycle(); settle();
        chk_ctl("md2_ctl", CTL_STALL);
        next_cycle(); settle();
        chk("md3_busy", md_busy, 1);
        chk("md3_done", md_done, 0);
        chk_ctl("md3_ctl", CTL_STALL);
        next_cycle(); settle();
        chk("md4_done", md_done, 1);
        chk("md4_busy", md_busy, 0);
        chk_ctl("md4_ctl", CTL_NORM);
        chk("md4_perf", stall_cycles, 5);
        next_cycle(); clear_inputs(); settle();
        chk("md5_done", md_done, 0);

        // Branch in the middle of a mult/div does not abort it.
        next_cycle(); ID_md_start = 1'b1; settle();
        chk("mdb0_issue", md_issue, 1);
        next_cycle(); ID_md_start = 1'b0; settle();
        chk("mdb1_busy", md_busy, 1);
        next_cycle(); ID_md_start = 1'b1; EX_branch_taken = 1'b1; settle();
        chk("mdb2_issue", md_issue, 0);
        chk("mdb2_busy", md_busy, 1);
        chk_ctl("mdb2_ctl", CTL_BR);
        next_cycle(); clear_inputs(); settle();
        chk("mdb3_busy", md_busy, 1);
        chk("mdb3_perf", stall_cycles, 5);
        // Back-to-back issue in the done cycle.
        next_cycle(); ID_md_start = 1'b1; settle();
        chk("mdb4_done", md_done, 1);
        chk("mdb4_issue", md_issue, 1);

        // Reset in the middle of the new operation.
        next_cycle(); clear_inputs(); settle();
        chk("mdr1_busy", md_busy, 1);
        next_cycle(); settle();
        #1 reset_n = 1'b0;
        #1;
        chk("mdr_rst_busy", md_busy, 0);
        chk_ctl("mdr_rst_ctl", CTL_RST);
        next_cycle(); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("post_rst_done", md_done, 0);
            chk("post_rst_busy", md_busy, 0);
            next_cycle();
        end
        settle();
        chk("post_rst_perf", stall_cycles, 0);

        // Held load-use drives the perf counter into saturation.
        next_cycle(); set_load_use();
        for (int i = 0; i < 18; i++) begin
            settle();
            if (i == 15) chk("sat_reach", stall_cycles, 15);
            next_cycle();
        end
        clear_inputs();
        settle();
        chk("sat_hold", stall_cycles, 15);
        chk_ctl("sat_ctl", CTL_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
